// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: framed serial-to-parallel receiver.
// Frame: start bit (0), WIDTH data bits, optional even-parity bit, stop bit (1).
// Build option: define SIPO_RX_PARITY_EN to add the parity bit and its check.
// Ports:
//   CLK        rising-edge clock
//   RESET      asynchronous active-high reset
//   IN         serial line, idles high
//   OUT        last received word (held until replaced)
//   OUT_VALID  OUT holds an unconsumed word
//   OUT_READY  consumer takes OUT when OUT_VALID && OUT_READY at an edge
//   FRAME_ERR  one-cycle pulse: stop bit sampled as 0
//   OVERRUN    one-cycle pulse: good frame arrived with buffer full, word dropped
//   PARITY_ERR one-cycle pulse: parity mismatch with good stop (0 without parity build)
module sipo_frame_rx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             FRAME_ERR,
  output logic             OVERRUN,
  output logic             PARITY_ERR
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
`ifdef SIPO_RX_PARITY_EN
  logic               par_bad_q, par_bad_d;
  logic               parity_err_q, parity_err_d;
`endif

  // State, datapath and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef SIPO_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state, shifting, buffer load and error pulses
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    out_d        = out_q;
    // A pending word is consumed on any edge where the consumer is ready
    out_valid_d  = out_valid_q & ~OUT_READY;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
`ifdef SIPO_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!IN) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
`ifdef SIPO_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
      end

      S_DATA: begin
        if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], IN};
        else           shift_d = {IN, shift_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        // Counter returns to 0 only through the state change
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d = '0;
`ifdef SIPO_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end

`ifdef SIPO_RX_PARITY_EN
      S_PARITY: begin
        // Even parity: data XOR parity bit must be 0
        par_bad_d = (^shift_q) ^ IN;
        state_d   = S_STOP;
      end
`endif

      S_STOP: begin
        // A low stop bit is never reused as a start bit
        state_d = S_IDLE;
        if (!IN) begin
          frame_err_d = 1'b1;
`ifdef SIPO_RX_PARITY_EN
        end else if (par_bad_q) begin
          parity_err_d = 1'b1;
`endif
        end else if (!out_valid_q || OUT_READY) begin
          out_d       = shift_q;
          out_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign OUT       = out_q;
  assign OUT_VALID = out_valid_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;
`ifdef SIPO_RX_PARITY_EN
  assign PARITY_ERR = parity_err_q;
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb_sipo_frame_rx: directed bench for sipo_frame_rx, MSB-first and LSB-first
// instances fed from the same serial stream.
module tb_sipo_frame_rx;

`ifdef SIPO_RX_PARITY_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 6;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b1;
  logic       ready = 1'b0;
  logic [3:0] out_m, out_l;
  logic       vld_m, vld_l, ferr_m, ferr_l, ovr_m, ovr_l, perr_m, perr_l;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses;

  always #5 clk = ~clk;

  sipo_frame_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .CLK(clk), .RESET(rst), .IN(sin), .OUT(out_m), .OUT_VALID(vld_m),
    .OUT_READY(ready), .FRAME_ERR(ferr_m), .OVERRUN(ovr_m), .PARITY_ERR(perr_m)
  );

  sipo_frame_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .CLK(clk), .RESET(rst), .IN(sin), .OUT(out_l), .OUT_VALID(vld_l),
    .OUT_READY(ready), .FRAME_ERR(ferr_l), .OVERRUN(ovr_l), .PARITY_ERR(perr_l)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    tick();
  endtask

  // Start bit, data d[3] first, then parity bit when built with parity
  task automatic send_head(input logic [3:0] d, input logic par_ok);
    send_bit(1'b0);
    for (int i = 3; i >= 0; i--) send_bit(d[i]);
`ifdef SIPO_RX_PARITY_EN
    send_bit((^d) ^ ~par_ok);
`else
    if (!par_ok) $display("note: parity request ignored in this build");
`endif
  endtask

  task automatic send_frame(input logic [3:0] d, input logic stop_bit);
    send_head(d, 1'b1);
    send_bit(stop_bit);
    sin = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (4) tick();
    chk("rst_out", out_m, 4'h0);
    chk("rst_valid", 4'(vld_m), 4'd0);
    chk("rst_ferr", 4'(ferr_m), 4'd0);
    chk("rst_ovr", 4'(ovr_m), 4'd0);
    rst = 1'b0;
    tick();
    tick();

    // 1: single frame 1101, latency and acceptance
    send_head(4'b1101, 1'b1);
    chk("t1_valid_before_stop", 4'(vld_m), 4'd0);
    send_bit(1'b1);
    chk("t1_valid", 4'(vld_m), 4'd1);
    chk("t1_out", out_m, 4'b1101);
    chk("t1_out_lsb", out_l, 4'b1011);
    chk("t1_ferr", 4'(ferr_m), 4'd0);
    chk("t1_perr", 4'(perr_m), 4'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t1_drained", 4'(vld_m), 4'd0);
    chk("t1_out_retained", out_m, 4'b1101);

    // 2: back-to-back with consumer stalled
    send_frame(4'b1101, 1'b1);
    chk("t2_first_valid", 4'(vld_m), 4'd1);
    chk("t2_first_ovr", 4'(ovr_m), 4'd0);
    send_frame(4'b0011, 1'b1);
    chk("t2_overrun", 4'(ovr_m), 4'd1);
    chk("t2_out_held", out_m, 4'b1101);
    tick();
    chk("t2_overrun_pulse_end", 4'(ovr_m), 4'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t2_drained", 4'(vld_m), 4'd0);
    tick();
    chk("t2_no_reload", 4'(vld_m), 4'd0);

    // 3: drain and load on the same edge
    send_frame(4'b1101, 1'b1);
    send_head(4'b0110, 1'b1);
    ready = 1'b1;
    send_bit(1'b1);
    ready = 1'b0;
    chk("t3_valid", 4'(vld_m), 4'd1);
    chk("t3_out", out_m, 4'b0110);
    chk("t3_out_lsb", out_l, 4'b0110);
    chk("t3_ovr", 4'(ovr_m), 4'd0);

    // 4: bad stop bit, then a good frame
    send_frame(4'b1010, 1'b0);
    chk("t4_ferr", 4'(ferr_m), 4'd1);
    chk("t4_valid_kept", 4'(vld_m), 4'd1);
    chk("t4_out_kept", out_m, 4'b0110);
    tick();
    chk("t4_ferr_pulse_end", 4'(ferr_m), 4'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    send_frame(4'b1001, 1'b1);
    chk("t4_out_next", out_m, 4'b1001);
    chk("t4_valid_next", 4'(vld_m), 4'd1);
    chk("t4_ferr_next", 4'(ferr_m), 4'd0);

    // 5: asynchronous reset mid-frame with a word buffered
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", 4'(vld_m), 4'd0);
    chk("t5_async_out", out_m, 4'h0);
    sin = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    send_frame(4'b0111, 1'b1);
    chk("t5_out", out_m, 4'b0111);
    chk("t5_out_lsb", out_l, 4'b1110);
    chk("t5_valid", 4'(vld_m), 4'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // Line held low: FRAME_ERR every frame length
    pulses = 0;
    sin = 1'b0;
    for (int i = 0; i < 2 * FLEN; i++) begin
      tick();
      if (ferr_m) pulses++;
    end
    sin = 1'b1;
    chk("stuck_low_pulses", 4'(pulses), 4'd2);
    chk("stuck_low_valid", 4'(vld_m), 4'd0);
    tick();
    tick();

`ifdef SIPO_RX_PARITY_EN
    // 6: parity good then parity bad; LSB-first instance sees 1101
    send_frame(4'b1011, 1'b1);
    chk("t6_out_lsb", out_l, 4'b1101);
    chk("t6_valid_lsb", 4'(vld_l), 4'd1);
    chk("t6_perr_good", 4'(perr_l), 4'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    send_head(4'b1011, 1'b0);
    send_bit(1'b1);
    chk("t6_perr", 4'(perr_l), 4'd1);
    chk("t6_no_load", 4'(vld_l), 4'd0);
    chk("t6_no_ovr", 4'(ovr_l), 4'd0);
    tick();
    chk("t6_perr_pulse_end", 4'(perr_l), 4'd0);
`else
    chk("perr_tied_low", 4'(perr_m), 4'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
- Downstream receive stage for the 4-bit PISO serialiser. Consumes a framed serial bit stream, one bit per CLK.
- Frame format: one start bit (0), WIDTH data bits, then one stop bit (1).
- Reassembles each frame into a parallel word and holds it in an output register with a valid/ready handshake.
- Flags framing errors and overruns.

Parameters:
- WIDTH, 4, data bits per frame (must be ≥2).
- MSB_FIRST, 1, 1 = first data bit received is OUT[WIDTH-1]; 0 = first data bit is OUT[0].

Ports:
- CLK  input  1  clock; all sampling on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- IN  input  1  serial data line; idles high.
- OUT  output  WIDTH  last received word.
- OUT_VALID  output  1  OUT holds an unconsumed word.
- OUT_READY  input  1  consumer accepts OUT when OUT_VALID && OUT_READY at a rising edge.
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled as 0.
- OVERRUN  output  1  one-cycle pulse: good frame completed while the buffer was full; new word dropped.
- PARITY_ERR  output  1  one-cycle pulse: parity mismatch (see Optional Feature); constant 0 when the feature is disabled.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, shift register=0, bit counter=0, OUT=0, OUT_VALID=0, FRAME_ERR=OVERRUN=PARITY_ERR=0.
- Reset mid-frame: partial frame discarded, buffered word lost; the first edge after deassertion is in IDLE.
- FSM states: IDLE, DATA, [PARITY], STOP.
  - IDLE: IN==0 at edge -> DATA, counter=0. IN==1 -> stay.
  - DATA: each edge shifts IN into the shift register (position per MSB_FIRST), counter++. At the edge sampling bit WIDTH-1 -> PARITY if PARITY_EN, else STOP.
  - STOP, IN==1: frame good -> IDLE.
  - STOP, IN==0: FRAME_ERR pulses for one cycle, word discarded -> IDLE. That 0 is not treated as a start bit.
- Counter width: $clog2(WIDTH). The counter wraps only via the state transition, never arithmetically.
- Buffer load: at the good-stop edge.
  - Buffer free (OUT_VALID==0), or draining this same edge (OUT_VALID && OUT_READY): OUT<=word, OUT_VALID<=1.
  - Otherwise: OUT and OUT_VALID unchanged, OVERRUN pulses one cycle.
- Handshake:
  - OUT_VALID drops at the edge where OUT_VALID && OUT_READY, unless a new word loads on that same edge; then it stays 1 and OUT updates.
  - OUT is stable while OUT_VALID=1 and not accepted.
  - OUT retains its last value after acceptance.
- Latency: start bit sampled at edge E0 -> OUT_VALID visible after edge E0+WIDTH+1 without parity, E0+WIDTH+2 with parity.
- Back-to-back frames: a start bit on the cycle immediately after the stop bit is accepted. There is no gap requirement.
- FRAME_ERR, OVERRUN and PARITY_ERR are mutually exclusive per frame. Frame priority: FRAME_ERR > PARITY_ERR > OVERRUN.
- IN held low forever: start detected, frame shifted in, FRAME_ERR at stop, then IDLE sees 0 and starts again. FRAME_ERR pulses every WIDTH+2 cycles.

Optional Feature:
- Macro SIPO_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state: one even-parity bit after the data bits, before the stop bit.
  - Expected relation: parity bit = XOR of the data bits.
  - On mismatch, the FSM still goes to STOP and checks the stop bit.
  - If the stop bit is good, PARITY_ERR pulses at the stop edge and the word is discarded (no load, no OVERRUN).
  - If the stop bit is bad, only FRAME_ERR pulses.
- Undefined: no PARITY state, frame length WIDTH+2, PARITY_ERR tied 0.

Test Plan:
1. Defaults, no parity. RESET=1 for 4 cycles then 0; IN bits 1,1,0,1,1,0,1,1 -> OUT_VALID=1 after the 6th edge from the start bit, OUT=4'b1101, FRAME_ERR=0. Hold OUT_READY=1 for one cycle -> OUT_VALID=0.
2. Back-to-back with consumer stalled (OUT_READY=0): frames 1101 then 0011 -> OUT stays 4'b1101, OVERRUN pulses once at the second stop. Then OUT_READY=1 -> OUT_VALID falls, no further load.
3. Simultaneous drain and load: OUT_READY=1 on the exact stop edge of frame 0110 while 1101 is buffered -> OUT_VALID stays 1, OUT=4'b0110, OVERRUN=0.
4. Bad stop: start, 1010, stop bit=0 -> FRAME_ERR one-cycle pulse, OUT_VALID unchanged. A following valid frame 1001 is received correctly.
5. RESET asserted asynchronously mid-edge-window after 2 data bits -> outputs 0 immediately. A new full frame 0111 after release -> OUT=4'b0111.
6. SIPO_RX_PARITY_EN, MSB_FIRST=0: frame start, data bits 1,0,1,1 (OUT=4'b1101), parity=1, stop -> OUT=4'b1101 valid. Same frame with parity=0 -> PARITY_ERR pulse, no load.
